// File: rtl/key_event.sv
// key_event: multi-channel active-low key front end.
// Each channel is synchronised, debounced and turned into one-cycle
// press / release / long-press / auto-repeat pulses plus a debounced level.
// All event outputs and the level are registered.
module key_event #(
    parameter int W         = 3,
    parameter int TIME_DEB  = 1_000_000,
    parameter int TIME_LONG = 50_000_000,
    parameter int TIME_REP  = 10_000_000,
    parameter int REPEAT_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_in,
    output logic [W-1:0] key_press,
    output logic [W-1:0] key_release,
    output logic [W-1:0] key_long,
    output logic [W-1:0] key_rep,
    output logic [W-1:0] key_state
);

    localparam int HOLD_MAX = (TIME_LONG > TIME_REP) ? TIME_LONG : TIME_REP;
    localparam int DEB_W    = $clog2(TIME_DEB);
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(TIME_DEB - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(TIME_LONG - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(TIME_REP - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    logic [W-1:0] sync1_r;
    logic [W-1:0] key_sync_r;

    // Two-stage synchroniser; idles at 1 because the keys are active-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= {W{1'b1}};
            key_sync_r <= {W{1'b1}};
        end else begin
            sync1_r    <= key_in;
            key_sync_r <= sync1_r;
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_ch
        state_t            state_r, state_s;
        logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_s;
        logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
        logic              long_flag_r, long_flag_s;
        logic              press_r, press_s;
        logic              release_r, release_s;
        logic              long_r, long_s;
        logic              rep_r, rep_s;
        logic              level_r, level_s;

        // Channel state, counters and registered event outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r     <= IDLE;
                deb_cnt_r   <= '0;
                hold_cnt_r  <= '0;
                long_flag_r <= 1'b0;
                press_r     <= 1'b0;
                release_r   <= 1'b0;
                long_r      <= 1'b0;
                rep_r       <= 1'b0;
                level_r     <= 1'b0;
            end else begin
                state_r     <= state_s;
                deb_cnt_r   <= deb_cnt_s;
                hold_cnt_r  <= hold_cnt_s;
                long_flag_r <= long_flag_s;
                press_r     <= press_s;
                release_r   <= release_s;
                long_r      <= long_s;
                rep_r       <= rep_s;
                level_r     <= level_s;
            end
        end

        // Next-state and next-event logic; a bounce always wins over a
        // counter reaching its terminal value.
        always_comb begin
            state_s     = state_r;
            deb_cnt_s   = deb_cnt_r;
            hold_cnt_s  = hold_cnt_r;
            long_flag_s = long_flag_r;
            press_s     = 1'b0;
            release_s   = 1'b0;
            long_s      = 1'b0;
            rep_s       = 1'b0;
            level_s     = level_r;
            case (state_r)
                IDLE: begin
                    if (!key_sync_r[g]) begin
                        state_s   = FILT_DN;
                        deb_cnt_s = '0;
                    end else begin
                        deb_cnt_s = '0;
                    end
                end
                FILT_DN: begin
                    if (key_sync_r[g]) begin
                        state_s   = IDLE;
                        deb_cnt_s = '0;
                    end else if (deb_cnt_r == DEB_LAST) begin
                        state_s     = DOWN;
                        press_s     = 1'b1;
                        level_s     = 1'b1;
                        hold_cnt_s  = '0;
                        long_flag_s = 1'b0;
                    end else begin
                        deb_cnt_s = deb_cnt_r + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_sync_r[g]) begin
                        // hold_cnt stays frozen while the release is filtered
                        state_s   = FILT_UP;
                        deb_cnt_s = '0;
                    end else if (!long_flag_r) begin
                        if (hold_cnt_r == LONG_LAST) begin
                            long_s      = 1'b1;
                            long_flag_s = 1'b1;
                            hold_cnt_s  = '0;
                        end else begin
                            hold_cnt_s = hold_cnt_r + 1'b1;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (hold_cnt_r == REP_LAST) begin
                            rep_s      = 1'b1;
                            hold_cnt_s = '0;
                        end else begin
                            hold_cnt_s = hold_cnt_r + 1'b1;
                        end
                    end else begin
                        if (hold_cnt_r != HOLD_SAT) begin
                            hold_cnt_s = hold_cnt_r + 1'b1;
                        end else begin
                            hold_cnt_s = hold_cnt_r;
                        end
                    end
                end
                FILT_UP: begin
                    if (!key_sync_r[g]) begin
                        state_s = DOWN;
                    end else if (deb_cnt_r == DEB_LAST) begin
                        state_s     = IDLE;
                        release_s   = 1'b1;
                        level_s     = 1'b0;
                        long_flag_s = 1'b0;
                        deb_cnt_s   = '0;
                    end else begin
                        deb_cnt_s = deb_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_s     = IDLE;
                    deb_cnt_s   = '0;
                    hold_cnt_s  = '0;
                    long_flag_s = 1'b0;
                    level_s     = 1'b0;
                end
            endcase
        end

        assign key_press[g]   = press_r;
        assign key_release[g] = release_r;
        assign key_long[g]    = long_r;
        assign key_rep[g]     = rep_r;
        assign key_state[g]   = level_r;
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed bench for key_event. Two instances share the key
// stimulus: one with auto-repeat, one without. A run-length model predicts
// every output on every cycle; literal edge numbers pin the key timings.
module tb_key_event;

    localparam int W  = 3;
    localparam int TD = 500;
    localparam int TL = 2000;
    localparam int TR = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] key_in;
    logic [W-1:0] press0, rel0, long0, rep0, st0;
    logic [W-1:0] press1, rel1, long1, rep1, st1;

    key_event #(.W(W), .TIME_DEB(TD), .TIME_LONG(TL), .TIME_REP(TR), .REPEAT_EN(1)) dut0 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_press(press0), .key_release(rel0), .key_long(long0),
        .key_rep(rep0), .key_state(st0)
    );

    key_event #(.W(W), .TIME_DEB(TD), .TIME_LONG(TL), .TIME_REP(TR), .REPEAT_EN(0)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_press(press1), .key_release(rel1), .key_long(long1),
        .key_rep(rep1), .key_state(st1)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int base     = 0;

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A key level flips once the synchronised pin has shown the opposite
    // level for TD+1 consecutive samples. The hold time counts samples where
    // the pin was low on this and the previous sample while pressed.
    logic [W-1:0] e_press[2], e_rel[2], e_long[2], e_rep[2], e_state[2];
    bit ms1[2][W], ms2[2][W], mprev[2][W], mpressed[2][W], mlflag[2][W];
    int mrun[2][W], mhold[2][W];

    initial begin : model
        bit s;
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < W; c++) begin
                    if (rst) begin
                        ms1[i][c] = 1'b1; ms2[i][c] = 1'b1; mprev[i][c] = 1'b1;
                        mpressed[i][c] = 1'b0; mlflag[i][c] = 1'b0;
                        mrun[i][c] = 0; mhold[i][c] = 0;
                        e_press[i][c] = 1'b0; e_rel[i][c] = 1'b0; e_long[i][c] = 1'b0;
                        e_rep[i][c] = 1'b0; e_state[i][c] = 1'b0;
                    end else begin
                        s = ms2[i][c];
                        ms2[i][c] = ms1[i][c];
                        ms1[i][c] = key_in[c];
                        e_press[i][c] = 1'b0; e_rel[i][c] = 1'b0;
                        e_long[i][c] = 1'b0; e_rep[i][c] = 1'b0;
                        if (!mpressed[i][c]) begin
                            mrun[i][c] = s ? 0 : mrun[i][c] + 1;
                            if (mrun[i][c] == TD + 1) begin
                                e_press[i][c] = 1'b1; mpressed[i][c] = 1'b1;
                                mrun[i][c] = 0; mhold[i][c] = 0; mlflag[i][c] = 1'b0;
                            end
                        end else begin
                            mrun[i][c] = s ? mrun[i][c] + 1 : 0;
                            if (mrun[i][c] == TD + 1) begin
                                e_rel[i][c] = 1'b1; mpressed[i][c] = 1'b0;
                                mrun[i][c] = 0; mlflag[i][c] = 1'b0;
                            end else if (!s && !mprev[i][c]) begin
                                mhold[i][c]++;
                                if (!mlflag[i][c] && mhold[i][c] == TL) begin
                                    e_long[i][c] = 1'b1; mlflag[i][c] = 1'b1; mhold[i][c] = 0;
                                end else if (mlflag[i][c] && i == 0 && mhold[i][c] == TR) begin
                                    e_rep[i][c] = 1'b1; mhold[i][c] = 0;
                                end
                            end
                        end
                        mprev[i][c] = s;
                        e_state[i][c] = mpressed[i][c];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + pulse counters ----------------
    int pc[2][4][W];

    initial begin : compare
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < W; c++) pc[i][k][c] = 0;
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                check_vec("press0", press0, e_press[0]);
                check_vec("release0", rel0, e_rel[0]);
                check_vec("long0", long0, e_long[0]);
                check_vec("rep0", rep0, e_rep[0]);
                check_vec("state0", st0, e_state[0]);
                check_vec("press1", press1, e_press[1]);
                check_vec("release1", rel1, e_rel[1]);
                check_vec("long1", long1, e_long[1]);
                check_vec("rep1", rep1, e_rep[1]);
                check_vec("state1", st1, e_state[1]);
            end
            for (int c = 0; c < W; c++) begin
                if (press0[c]) pc[0][0][c]++;
                if (rel0[c])   pc[0][1][c]++;
                if (long0[c])  pc[0][2][c]++;
                if (rep0[c])   pc[0][3][c]++;
                if (press1[c]) pc[1][0][c]++;
                if (rel1[c])   pc[1][1][c]++;
                if (long1[c])  pc[1][2][c]++;
                if (rep1[c])   pc[1][3][c]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] sig0(input int kind);
        case (kind)
            0:       return press0;
            1:       return rel0;
            2:       return long0;
            3:       return rep0;
            default: return '0;
        endcase
    endfunction

    // Run until relative edge e has happened, then settle 1 time unit.
    task automatic goto(input int e);
        while (cyc < base + e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the next pulse of a kind on a channel; check its relative edge.
    task automatic wait_pulse(input int kind, input int ch, input int exp_rel, input string name);
        int got;
        logic [W-1:0] v;
        got = -1;
        while (got < 0 && (cyc - base) <= exp_rel + 20) begin
            @(negedge clk);
            v = sig0(kind);
            if (v[ch]) got = cyc - base;
        end
        check_int(name, got, exp_rel);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int snap_a, snap_b, snap_c;
        rst    = 1'b1;
        key_in = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle keys
        base = cyc;
        goto(200);
        check_vec("t1_state", st0, 3'b000);

        // 2: low for less than the debounce window
        key_in = 3'b110; base = cyc;
        snap_a = pc[0][0][0]; snap_b = pc[0][1][0];
        goto(200);
        check_vec("t2_state", st0, 3'b000);
        key_in = 3'b111;
        goto(800);
        check_int("t2_press_cnt", pc[0][0][0] - snap_a, 0);
        check_int("t2_release_cnt", pc[0][1][0] - snap_b, 0);

        // 3: 1500-cycle press on key 0
        key_in = 3'b110; base = cyc; snap_a = pc[0][2][0];
        wait_pulse(0, 0, 503, "t3_press_edge");
        check_vec("t3_state", st0, 3'b001);
        goto(1500);
        key_in = 3'b111;
        wait_pulse(1, 0, 2003, "t3_release_edge");
        check_int("t3_long_cnt", pc[0][2][0] - snap_a, 0);
        goto(2700);

        // 4: long hold on key 1 with repeat (dut0) and without (dut1)
        key_in = 3'b101; base = cyc;
        snap_a = pc[0][3][1]; snap_b = pc[1][2][1]; snap_c = pc[1][3][1];
        wait_pulse(0, 1, 503, "t4_press_edge");
        wait_pulse(2, 1, 2503, "t4_long_edge");
        wait_pulse(3, 1, 2903, "t4_rep1_edge");
        wait_pulse(3, 1, 3303, "t4_rep2_edge");
        goto(3500);
        key_in = 3'b111;
        wait_pulse(1, 1, 4003, "t4_release_edge");
        check_int("t4_rep_cnt", pc[0][3][1] - snap_a, 2);
        check_int("t7_norep_long_cnt", pc[1][2][1] - snap_b, 1);
        check_int("t7_norep_rep_cnt", pc[1][3][1] - snap_c, 0);
        goto(4600);

        // 5: two keys in the same cycle
        key_in = 3'b100; base = cyc;
        wait_pulse(0, 0, 503, "t5_press_edge");
        check_vec("t5_press_pair", press0, 3'b011);
        goto(700);
        key_in = 3'b111;
        goto(1300);

        // 6: reset while key 2 is held
        key_in = 3'b011; base = cyc;
        goto(800);
        check_vec("t6_state_before", st0, 3'b100);
        snap_a = pc[0][1][2];
        rst = 1'b1;
        #1;
        check_vec("t6_state_async", st0, 3'b000);
        check_vec("t6_release_async", rel0, 3'b000);
        goto(802);
        rst = 1'b0; base = cyc;
        wait_pulse(0, 2, 503, "t6_repress_edge");
        check_int("t6_release_cnt", pc[0][1][2] - snap_a, 0);
        goto(600);
        key_in = 3'b111;
        goto(1200);

        // 8: short release glitch while held
        key_in = 3'b110; base = cyc;
        snap_a = pc[0][0][0]; snap_b = pc[0][1][0];
        wait_pulse(0, 0, 503, "t8_press_edge");
        goto(700);
        key_in = 3'b111;
        goto(800);
        key_in = 3'b110;
        goto(1000);
        key_in = 3'b111;
        wait_pulse(1, 0, 1503, "t8_release_edge");
        check_int("t8_press_cnt", pc[0][0][0] - snap_a, 1);
        check_int("t8_release_cnt", pc[0][1][0] - snap_b, 1);
        goto(1600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Parametrised multi-channel key front end; successor to the single-event debouncer.
- Each of W active-low mechanical keys is synchronised and debounced independently.
- Per key, the block issues one-cycle event pulses: press, release, long-press and optional auto-repeat. It also provides a debounced level.
- Sits between board key pins and application control FSMs, for example menu or LED mode logic.

Parameters:
- W, 3: number of independent key channels.
- TIME_DEB, 1_000_000: debounce window in clk cycles (20 ms at 50 MHz); legal range ≥2.
- TIME_LONG, 50_000_000: hold time in cycles, measured from the press event, before the long pulse; must be > TIME_DEB.
- TIME_REP, 10_000_000: auto-repeat period in cycles after the long event; ≥2.
- REPEAT_EN, 1: 1 enables auto-repeat pulses; 0 means key_rep is never asserted.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- key_in, input, W: raw key pins, active-low (0 = pressed), asynchronous to clk.
- key_press, output, W: one-cycle pulse per channel on a debounced press.
- key_release, output, W: one-cycle pulse per channel on a debounced release.
- key_long, output, W: one-cycle pulse when the hold reaches TIME_LONG.
- key_rep, output, W: one-cycle pulse every TIME_REP while held after key_long.
- key_state, output, W: debounced level, 1 = held; registered.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0.
  - Synchroniser flops are 1 (released).
  - All channel FSMs go to IDLE, counters to 0, long_flag to 0.
- Reset asserted mid-press drops all channels to IDLE immediately and emits no release pulse.
- Synchroniser: 2 flip-flop stages per bit; the FSMs see only key_sync (stage 2).
- Each channel has its own FSM (IDLE, FILT_DN, DOWN, FILT_UP), a debounce counter deb_cnt of width $clog2(TIME_DEB) and a hold counter hold_cnt of width $clog2(max(TIME_LONG,TIME_REP)).
- IDLE:
  - key_sync=0 → FILT_DN with deb_cnt=0.
- FILT_DN:
  - key_sync=1 (bounce) → IDLE, deb_cnt=0, no event.
  - Otherwise deb_cnt increments.
  - At deb_cnt==TIME_DEB-1 → DOWN: pulse key_press, set key_state=1, hold_cnt=0, long_flag=0.
- DOWN:
  - key_sync=1 → FILT_UP with deb_cnt=0; hold_cnt is frozen.
  - Otherwise hold_cnt increments.
  - When long_flag=0 and hold_cnt==TIME_LONG-1: pulse key_long, set long_flag=1, hold_cnt=0.
  - When long_flag=1, REPEAT_EN=1 and hold_cnt==TIME_REP-1: pulse key_rep, hold_cnt=0.
  - When long_flag=1 and REPEAT_EN=0, hold_cnt saturates; no further events.
- FILT_UP:
  - key_sync=0 (bounce) → DOWN; hold_cnt resumes from its frozen value.
  - Otherwise deb_cnt increments.
  - At deb_cnt==TIME_DEB-1 → IDLE: pulse key_release, key_state=0, long_flag=0.
- Latency:
  - With key_in falling and held low, key_press is high for the cycle following clock edge TIME_DEB+3 (2 edges synchroniser, 1 edge IDLE→FILT_DN, TIME_DEB edges filter).
  - Release is symmetrical: key_release follows edge TIME_DEB+3 after key_in rises.
  - key_long follows TIME_LONG edges after the key_press edge; each key_rep follows TIME_REP edges after the previous long or rep pulse.
- Event exclusivity:
  - At most one of press, long, rep or release is asserted per channel per cycle.
  - Pulses are never wider than 1 cycle.
- Simultaneous keys:
  - Channels are fully independent.
  - Any combination of channels may pulse in the same cycle; there is no priority or masking.
- Release during the debounce of a press (a glitch shorter than TIME_DEB) generates no events at all.
- A release shorter than TIME_DEB while held generates no release and no new press.

Test Plan (W=3, TIME_DEB=500, TIME_LONG=2000, TIME_REP=400, REPEAT_EN=1, 20 ns clk):
1. Reset, then key_in=3'b111 for 200 cycles → all outputs stay 0, key_state=3'b000.
2. key_in=3'b110 for 200 cycles, then 3'b111 → no key_press, no key_release; key_state[0] stays 0.
3. key_in=3'b110 at edge 0, held 1500 cycles, then released → key_press[0] after edge 503, key_state[0]=1; key_release[0] after edge 1503+500; key_long is never asserted.
4. key_in=3'b101 held 3500 cycles:
   - key_press[1] after edge 503.
   - key_long[1] after edge 2503.
   - key_rep[1] after edges 2903 and 3303.
   - After release, key_release[1] arrives with no further rep.
5. key_in=3'b100 (two keys in the same cycle) → key_press[0] and key_press[1] both pulse in the same cycle; bit 2 is untouched.
6. Hold key 2 to DOWN, assert rst at cycle 800 → all outputs are 0 immediately (asynchronously) with no key_release. After rst=0 with the key still held, a fresh key_press[2] follows edge 503.
7. Rerun case 4 with REPEAT_EN=0 → key_long[1] at edge 2503, no key_rep thereafter.
